// File: rtl/ps2_keypad_entry.sv
// ---------------------------------------------------------------------------
// ps2_keypad_entry
//
// PS/2 keyboard receiver plus decimal-entry decoder. It turns key presses
// into an 8-bit committed value and single-cycle start/load strobes for the
// coin controller.
//
// Ports
//   clock          in   system clock; everything updates on the rising edge
//   reset          in   asynchronous, active-high; clears all state
//   ps2_clk        in   raw PS/2 clock (asynchronous)
//   ps2_dat        in   raw PS/2 data (asynchronous)
//   live_value     out  decimal accumulator being typed
//   digit_count    out  digits currently held in the accumulator (0..3)
//   entered_value  out  last value committed by Enter
//   value_valid    out  one-cycle pulse when entered_value updates
//   start_pulse    out  one-cycle pulse on the S make code
//   load_pulse     out  one-cycle pulse on the L make code
//   overflow       out  sticky; entry exceeded 255 (cleared by Enter/Escape)
//   frame_error    out  one-cycle pulse on a bad or aborted frame
//   scan_code      out  last good scan code received
//
// Handshake: there is no back-pressure. code_strobe is a one-cycle valid
// qualifying scan_code; the decoder always consumes it in that same cycle.
// The output pulses are one-cycle valids with no ready.
// ---------------------------------------------------------------------------
module ps2_keypad_entry #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] live_value,
    output logic [1:0] digit_count,
    output logic [7:0] entered_value,
    output logic       value_valid,
    output logic       start_pulse,
    output logic       load_pulse,
    output logic       overflow,
    output logic       frame_error,
    output logic [7:0] scan_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    // -----------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // -----------------------------------------------------------------------
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    // Flops clear to 0 so that a line already high at reset release shows a
    // rising edge, never a spurious falling one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_dat;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // -----------------------------------------------------------------------
    // Receiver FSM
    // -----------------------------------------------------------------------
    rx_state_t      state_q, state_d;
    logic [2:0]     bit_cnt;
    logic [7:0]     shift_q;
    logic           parity_q;
    logic [TW-1:0]  timeout_cnt;
    logic           timeout_hit;
    logic           start_err;
    logic           frame_done;
    logic           frame_good;
    logic           code_strobe;

    // timeout_cnt holds the number of cycles since the last falling edge, so
    // the abort registers frame_error exactly TIMEOUT_CYCLES after that edge.
    assign timeout_hit = (state_q != ST_IDLE) && !fall &&
                         (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_err  = 1'b0;
        frame_done = 1'b0;
        frame_good = 1'b0;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2) state_d = ST_DATA;
                    else         start_err = 1'b1;
                end
                ST_DATA: begin
                    if (bit_cnt == 3'd7) state_d = ST_PARITY;
                end
                ST_PARITY: state_d = ST_STOP;
                ST_STOP: begin
                    state_d    = ST_IDLE;
                    frame_done = 1'b1;
                    // Odd parity over data+parity, and stop bit must be 1.
                    frame_good = (^{shift_q, parity_q}) & dat_s2;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt     <= 3'd0;
            shift_q     <= 8'd0;
            parity_q    <= 1'b0;
            timeout_cnt <= '0;
            code_strobe <= 1'b0;
            scan_code   <= 8'd0;
            frame_error <= 1'b0;
        end else begin
            code_strobe <= 1'b0;
            frame_error <= 1'b0;

            if (fall)                   timeout_cnt <= TW'(1);
            else if (state_q == ST_IDLE) timeout_cnt <= '0;
            else                        timeout_cnt <= timeout_cnt + TW'(1);

            if (fall && !timeout_hit) begin
                case (state_q)
                    ST_IDLE:   bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shift_q <= {dat_s2, shift_q[7:1]};  // LSB arrives first
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: parity_q <= dat_s2;
                    default:   ;
                endcase
            end

            if (frame_done) begin
                if (frame_good) begin
                    code_strobe <= 1'b1;
                    scan_code   <= shift_q;
                end else begin
                    frame_error <= 1'b1;
                end
            end

            if (start_err || timeout_hit) frame_error <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Decoder
    // -----------------------------------------------------------------------
    logic        is_digit;
    logic [3:0]  digit_val;
    logic [11:0] digit_sum;
    logic        break_pending;
    logic        ext_pending;

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (scan_code)
            8'h45: digit_val = 4'd0;
            8'h16: digit_val = 4'd1;
            8'h1E: digit_val = 4'd2;
            8'h26: digit_val = 4'd3;
            8'h25: digit_val = 4'd4;
            8'h2E: digit_val = 4'd5;
            8'h36: digit_val = 4'd6;
            8'h3D: digit_val = 4'd7;
            8'h3E: digit_val = 4'd8;
            8'h46: digit_val = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end

    // live_value*10 + digit; 12 bits holds the worst case 2559.
    assign digit_sum = ({4'd0, live_value} << 3) + ({4'd0, live_value} << 1) +
                       {8'd0, digit_val};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            live_value    <= 8'd0;
            digit_count   <= 2'd0;
            entered_value <= 8'd0;
            value_valid   <= 1'b0;
            start_pulse   <= 1'b0;
            load_pulse    <= 1'b0;
            overflow      <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            start_pulse <= 1'b0;
            load_pulse  <= 1'b0;

            if (code_strobe) begin
                if (break_pending) begin
                    // Code after a break prefix is a release: swallow it.
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end else if (ext_pending) begin
                    // E0 F0 xx: keep ext set so xx is swallowed with both flags.
                    if (scan_code == 8'hF0) break_pending <= 1'b1;
                    else                    ext_pending   <= 1'b0;
                end else begin
                    case (scan_code)
                        8'hF0: break_pending <= 1'b1;
                        8'hE0: ext_pending   <= 1'b1;
                        8'h66: begin
                            if (digit_count != 2'd0) begin
                                live_value  <= live_value / 8'd10;
                                digit_count <= digit_count - 2'd1;
                            end
                        end
                        8'h76: begin
                            live_value  <= 8'd0;
                            digit_count <= 2'd0;
                            overflow    <= 1'b0;
                        end
                        8'h5A: begin
                            entered_value <= live_value;
                            value_valid   <= 1'b1;
                            live_value    <= 8'd0;
                            digit_count   <= 2'd0;
                            overflow      <= 1'b0;
                        end
                        8'h1B: start_pulse <= 1'b1;
                        8'h4B: load_pulse  <= 1'b1;
                        default: begin
                            if (is_digit && digit_count != 2'd3) begin
                                digit_count <= digit_count + 2'd1;
                                if (digit_sum > 12'd255) begin
                                    live_value <= 8'd255;
                                    overflow   <= 1'b1;
                                end else begin
                                    live_value <= digit_sum[7:0];
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_keypad_entry.sv
// ---------------------------------------------------------------------------
// tb_ps2_keypad_entry
//
// Drives PS/2 frames into ps2_keypad_entry and checks the decoded state.
// Every output pulse (value_valid / start_pulse / load_pulse / frame_error)
// is matched against an expected queue filled when the stimulus is sent.
// ---------------------------------------------------------------------------
module tb_ps2_keypad_entry;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 8;     // PS/2 half period in system clocks

    localparam logic [1:0] EV_VALID = 2'd0;
    localparam logic [1:0] EV_START = 2'd1;
    localparam logic [1:0] EV_LOAD  = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] live_value;
    logic [1:0] digit_count;
    logic [7:0] entered_value;
    logic       value_valid;
    logic       start_pulse;
    logic       load_pulse;
    logic       overflow;
    logic       frame_error;
    logic [7:0] scan_code;

    int checks_total  = 0;
    int checks_passed = 0;
    logic [9:0] exp_q[$];

    ps2_keypad_entry #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clock         (clock),
        .reset         (reset),
        .ps2_clk       (ps2_clk),
        .ps2_dat       (ps2_dat),
        .live_value    (live_value),
        .digit_count   (digit_count),
        .entered_value (entered_value),
        .value_valid   (value_valid),
        .start_pulse   (start_pulse),
        .load_pulse    (load_pulse),
        .overflow      (overflow),
        .frame_error   (frame_error),
        .scan_code     (scan_code)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- pulse scoreboard ----------------
    always @(negedge clock) begin : pulse_monitor
        logic [9:0] obs;
        logic [9:0] exp;
        int         n;
        n = int'(value_valid) + int'(start_pulse) + int'(load_pulse) + int'(frame_error);
        if (n != 0) begin
            if (value_valid)      obs = {EV_VALID, entered_value};
            else if (start_pulse) obs = {EV_START, 8'h00};
            else if (load_pulse)  obs = {EV_LOAD, 8'h00};
            else                  obs = {EV_ERR, 8'h00};
            checks_total++;
            if (n > 1) begin
                $display("FAIL pulse_exclusive: %0d pulses high at once, required 1 (t=%0t)", n, $time);
            end else if (exp_q.size() == 0) begin
                $display("FAIL unexpected_pulse: actual event %h, required none (t=%0t)", obs, $time);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp)
                    $display("FAIL pulse_event: actual %h, required %h (t=%0t)", obs, exp, $time);
                else
                    checks_passed++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_dat = b;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input logic flip_parity);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit((~^code) ^ flip_parity);
        ps2_bit(1'b1);
        repeat (20) @(negedge clock);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset   = 1'b1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checks_total++;
        if ({live_value, digit_count, entered_value, overflow, scan_code} !== 27'd0)
            $display("FAIL reset_values: actual live=%0d cnt=%0d ent=%0d ovf=%0b scan=%h, required all 0",
                     live_value, digit_count, entered_value, overflow, scan_code);
        else checks_passed++;
        checks_total++;
        if ({value_valid, start_pulse, load_pulse, frame_error} !== 4'd0)
            $display("FAIL reset_pulses: actual %b, required 0000",
                     {value_valid, start_pulse, load_pulse, frame_error});
        else checks_passed++;
    endtask

    task automatic test_basic_entry();
        send_frame(8'h16, 1'b0);
        checks_total++;
        if ({live_value, digit_count, scan_code} !== {8'd1, 2'd1, 8'h16})
            $display("FAIL basic_digit1: actual live=%0d cnt=%0d scan=%h, required 1 1 16",
                     live_value, digit_count, scan_code);
        else checks_passed++;
        send_frame(8'h1E, 1'b0);
        checks_total++;
        if ({live_value, digit_count} !== {8'd12, 2'd2})
            $display("FAIL basic_digit2: actual live=%0d cnt=%0d, required 12 2", live_value, digit_count);
        else checks_passed++;
        exp_q.push_back({EV_VALID, 8'd12});
        send_frame(8'h5A, 1'b0);
        checks_total++;
        if ({entered_value, live_value, digit_count, overflow} !== {8'd12, 8'd0, 2'd0, 1'b0})
            $display("FAIL basic_enter: actual ent=%0d live=%0d cnt=%0d ovf=%0b, required 12 0 0 0",
                     entered_value, live_value, digit_count, overflow);
        else checks_passed++;
    endtask

    task automatic test_overflow();
        send_frame(8'h1E, 1'b0);
        send_frame(8'h2E, 1'b0);
        send_frame(8'h36, 1'b0);
        checks_total++;
        if ({live_value, digit_count, overflow} !== {8'd255, 2'd3, 1'b1})
            $display("FAIL overflow_set: actual live=%0d cnt=%0d ovf=%0b, required 255 3 1",
                     live_value, digit_count, overflow);
        else checks_passed++;
        send_frame(8'h3D, 1'b0);
        checks_total++;
        if ({live_value, digit_count, overflow} !== {8'd255, 2'd3, 1'b1})
            $display("FAIL fourth_digit: actual live=%0d cnt=%0d ovf=%0b, required 255 3 1",
                     live_value, digit_count, overflow);
        else checks_passed++;
        exp_q.push_back({EV_VALID, 8'd255});
        send_frame(8'h5A, 1'b0);
        checks_total++;
        if ({entered_value, overflow, digit_count} !== {8'd255, 1'b0, 2'd0})
            $display("FAIL overflow_enter: actual ent=%0d ovf=%0b cnt=%0d, required 255 0 0",
                     entered_value, overflow, digit_count);
        else checks_passed++;
    endtask

    task automatic test_backspace();
        logic [7:0] exp_live[5];
        logic [1:0] exp_cnt[5];
        exp_live = '{8'd123, 8'd12, 8'd1, 8'd0, 8'd0};
        exp_cnt  = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0};
        send_frame(8'h16, 1'b0);
        send_frame(8'h1E, 1'b0);
        send_frame(8'h26, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) send_frame(8'h66, 1'b0);
            checks_total++;
            if ({live_value, digit_count} !== {exp_live[i], exp_cnt[i]})
                $display("FAIL backspace_step%0d: actual live=%0d cnt=%0d, required %0d %0d",
                         i, live_value, digit_count, exp_live[i], exp_cnt[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_keys();
        exp_q.push_back({EV_START, 8'h00});
        send_frame(8'h1B, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1B, 1'b0);       // release of S: no pulse
        exp_q.push_back({EV_LOAD, 8'h00});
        send_frame(8'h4B, 1'b0);
        // extended make and extended break of a digit key are both ignored
        send_frame(8'hE0, 1'b0);
        send_frame(8'h16, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h16, 1'b0);
        checks_total++;
        if ({live_value, digit_count, scan_code} !== {8'd0, 2'd0, 8'h16})
            $display("FAIL ext_ignored: actual live=%0d cnt=%0d scan=%h, required 0 0 16",
                     live_value, digit_count, scan_code);
        else checks_passed++;
        send_frame(8'h16, 1'b0);       // flags must be clear again
        checks_total++;
        if ({live_value, digit_count} !== {8'd1, 2'd1})
            $display("FAIL after_ext: actual live=%0d cnt=%0d, required 1 1", live_value, digit_count);
        else checks_passed++;
        send_frame(8'h76, 1'b0);
        checks_total++;
        if ({live_value, digit_count, overflow} !== 11'd0)
            $display("FAIL escape: actual live=%0d cnt=%0d ovf=%0b, required 0 0 0",
                     live_value, digit_count, overflow);
        else checks_passed++;
    endtask

    task automatic test_bad_parity();
        send_frame(8'h1E, 1'b0);
        exp_q.push_back({EV_ERR, 8'h00});
        send_frame(8'h16, 1'b1);
        checks_total++;
        if ({live_value, digit_count, scan_code} !== {8'd2, 2'd1, 8'h1E})
            $display("FAIL bad_parity: actual live=%0d cnt=%0d scan=%h, required 2 1 1e",
                     live_value, digit_count, scan_code);
        else checks_passed++;
        send_frame(8'h76, 1'b0);
    endtask

    task automatic test_timeout();
        int err_at;
        err_at = 0;
        send_frame(8'h26, 1'b0);       // live = 3
        exp_q.push_back({EV_ERR, 8'h00});
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clock);
        ps2_dat = 1'b1;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;                // last edge; clock then stays idle
        // Two synchroniser stages put the detected edge at sample 2.
        for (int i = 1; i <= TIMEOUT + 10; i++) begin
            @(negedge clock);
            if (i == HALF) ps2_clk = 1'b1;
            if (frame_error && err_at == 0) err_at = i;
        end
        checks_total++;
        if (err_at !== TIMEOUT + 2)
            $display("FAIL timeout_latency: actual sample %0d, required %0d", err_at, TIMEOUT + 2);
        else checks_passed++;
        send_frame(8'h45, 1'b0);
        checks_total++;
        if ({live_value, digit_count, scan_code} !== {8'd30, 2'd2, 8'h45})
            $display("FAIL after_timeout: actual live=%0d cnt=%0d scan=%h, required 30 2 45",
                     live_value, digit_count, scan_code);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_frame();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clock);
        ps2_dat = 1'b0;
        repeat (HALF) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks_total++;
        if ({live_value, digit_count, entered_value, overflow, scan_code,
             value_valid, start_pulse, load_pulse, frame_error} !== 31'd0)
            $display("FAIL reset_mid_frame: actual live=%0d cnt=%0d ent=%0d scan=%h, required all 0",
                     live_value, digit_count, entered_value, scan_code);
        else checks_passed++;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        repeat (4) @(negedge clock);
        reset = 1'b0;
        repeat (TIMEOUT + 20) @(negedge clock);
        checks_total++;
        if ({live_value, digit_count, entered_value, overflow, scan_code} !== 27'd0)
            $display("FAIL post_reset_idle: actual live=%0d cnt=%0d scan=%h, required all 0",
                     live_value, digit_count, scan_code);
        else checks_passed++;
        send_frame(8'h26, 1'b0);
        checks_total++;
        if ({live_value, digit_count, scan_code} !== {8'd3, 2'd1, 8'h26})
            $display("FAIL post_reset_frame: actual live=%0d cnt=%0d scan=%h, required 3 1 26",
                     live_value, digit_count, scan_code);
        else checks_passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic_entry();
        test_overflow();
        test_backspace();
        test_keys();
        test_bad_parity();
        test_timeout();
        test_reset_mid_frame();
        repeat (10) @(negedge clock);
        checks_total++;
        if (exp_q.size() != 0)
            $display("FAIL pending_events: actual %0d expected pulses never seen, required 0", exp_q.size());
        else checks_passed++;
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/ps2_keypad_entry.md
Name: ps2_keypad_entry

Overview:
- Upstream input stage for the top-level coin design: a PS/2 keyboard receiver and decimal-entry decoder.
- Turns typed digits, Enter, Backspace, Escape, S and L into:
  - an 8-bit committed value, which replaces the SW[7:0] amount/key inputs to the datapath;
  - single-cycle start/load pulses, which replace ~KEY[0]/~KEY[1] into the main controller.
- Runs on the 50 MHz system clock and oversamples the asynchronous PS/2 lines.

Parameters:
- TIMEOUT_CYCLES, 50000, system clocks allowed between PS/2 falling edges inside a frame before the partial frame is aborted (1 ms at 50 MHz).

Ports:
- clock  input  1  system clock, 50 MHz; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ps2_clk  input  1  raw PS/2 clock, asynchronous.
- ps2_dat  input  1  raw PS/2 data, asynchronous.
- live_value  output  8  decimal accumulator being typed.
- digit_count  output  2  digits currently in the accumulator (0..3).
- entered_value  output  8  last value committed by Enter.
- value_valid  output  1  one-cycle pulse when entered_value updates.
- start_pulse  output  1  one-cycle pulse on S make code.
- load_pulse  output  1  one-cycle pulse on L make code.
- overflow  output  1  sticky; set when an entry exceeded 255; cleared by Enter, Escape or reset.
- frame_error  output  1  one-cycle pulse on a bad or aborted frame.
- scan_code  output  8  last good scan code received (debug/HEX display).

Behaviour:
- Reset value of every output is 0.
- Synchronisation:
  - ps2_clk and ps2_dat each pass through 2 flops.
  - A falling edge is synced-clk 1 in the previous cycle and 0 in the current cycle.
  - Data is sampled on that same cycle.
- Receiver FSM:
  - IDLE: a falling edge with data=0 moves to DATA; a falling edge with data=1 stays in IDLE and pulses frame_error.
  - DATA: captures 8 bits LSB first, using a 3-bit counter.
  - PARITY: captures the parity bit.
  - STOP: captures the stop bit, then returns to IDLE.
  - A frame is good only if the number of ones across the 8 data bits plus parity is odd and the stop bit is 1.
  - If good: the code strobe asserts in the cycle after the stop edge (N+1), and scan_code updates at N+1.
  - If bad: frame_error pulses at N+1 and the code is discarded.
- Timeout:
  - A counter runs in any state other than IDLE and clears on each falling edge.
  - When it reaches TIMEOUT_CYCLES the FSM returns to IDLE and frame_error pulses.
- Decoder: acts on the code strobe; all resulting output changes appear at N+2.
  - 0xF0 sets break_pending. The next code clears it and is otherwise ignored, so key releases never act.
  - 0xE0 sets ext_pending. The next code clears it and is ignored, so extended keys are ignored.
  - If 0xE0 is followed by 0xF0, both flags are honoured: break_pending is set and ext_pending is kept. The next code clears both and is ignored.
- Digit make codes map as: 0x45=0, 0x16=1, 0x1E=2, 0x26=3, 0x25=4, 0x2E=5, 0x36=6, 0x3D=7, 0x3E=8, 0x46=9.
- Digit entry:
  - If digit_count<3: compute live_value*10+d in 12 bits and increment digit_count.
  - If the result is >255: live_value=255 and overflow=1.
  - If digit_count==3: the digit is ignored and no state changes.
- Backspace (0x66):
  - If digit_count>0: live_value=live_value/10 (integer division) and decrement digit_count.
  - If digit_count==0: no-op.
  - overflow is unchanged.
- Escape (0x76): live_value=0, digit_count=0, overflow=0.
- Enter (0x5A):
  - entered_value=live_value and value_valid=1 for one cycle, both at N+2.
  - live_value, digit_count and overflow clear in that same cycle.
  - Enter with digit_count==0 commits 0 and still pulses value_valid.
- Other keys:
  - 0x1B (S) pulses start_pulse; 0x4B (L) pulses load_pulse.
  - Any other code only updates scan_code.
- At most one of value_valid, start_pulse and load_pulse is high in any cycle.
- Reset asserted mid-frame aborts the frame immediately. After release the FSM is in IDLE with all flags clear; no frame_error pulse.

Test Plan:
- Good frame 0x16 (parity bit 0), then 0x1E, then 0x5A (parity 1) at a 10 kHz PS/2 clock -> live_value 1 then 12; at Enter, entered_value=12 and value_valid high exactly 1 cycle; live_value=0, digit_count=0.
- Type 2,5,6 -> live_value=255, overflow=1. A fourth digit 7 is ignored. Enter -> entered_value=255, overflow cleared.
- Type 1,2,3, then Backspace, Backspace -> live_value 123, 12, 1; digit_count 3, 2, 1. Backspace twice more -> 0, then no-op with digit_count stays 0.
- Sequence 0x1B, 0xF0, 0x1B, 0x4B -> start_pulse once, load_pulse once; the break code produces no pulse.
- Frame 0x16 with a flipped parity bit -> frame_error 1 cycle; live_value unchanged; scan_code unchanged.
- Stop the PS/2 clock after 4 data bits -> frame_error exactly TIMEOUT_CYCLES after the last edge; the following good frame 0x45 is decoded correctly. Then assert reset mid-frame -> all outputs 0 and no error pulse.
